// File: rtl/cali_ram_reader.sv
// Port-2 read master for the calibration RAM: sweeps channels 0..NUM_CH-1 per frame
// and streams {data, chan, last} through a prefetch FIFO. Optional checksum: CALI_RD_CHECKSUM_EN.
module cali_ram_reader #(
  parameter int NUM_CH     = 320,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_start,
  output logic [ADDR_W-1:0]     ram_address,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata,
  output logic [DATA_W-1:0]     coef_data,
  output logic [ADDR_W-1:0]     coef_chan,
  output logic                  coef_last,
  output logic                  coef_valid,
  input  logic                  coef_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_overrun
`ifdef CALI_RD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     coef_sum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  // Stream handshake: a beat transfers on every cycle where coef_valid && coef_ready;
  // while coef_valid is high and coef_ready low, data/chan/last hold stable.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] chan;
    logic              last;
  } entry_t;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  chan_q, chan_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             fifo_q [FIFO_DEPTH];

  entry_t             head;
  entry_t             push_entry;
  logic [CNT_W-1:0]   occupancy;
  logic               issue;
  logic               last_issue;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic               sweep_done;
  logic               accept;

  // Shared control terms
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    head       = fifo_q[rd_ptr_q];
    // Reads already in flight count against FIFO space so a push never meets a full FIFO.
    occupancy  = count_q + CNT_W'(inflight_q);
    issue      = (state_q == ST_FETCH) && (occupancy < DEPTH_C);
    last_issue = issue && (addr_q == LAST_ADDR);
    push       = inflight_q;
    pop        = !fifo_empty && coef_ready;
    sweep_done = (state_q == ST_DRAIN) && pop && head.last && !inflight_q &&
                 (count_q == CNT_W'(1));
    accept     = frame_start && ((state_q == ST_IDLE) || sweep_done);
    push_entry.data = ram_readdata;
    push_entry.chan = chan_q;
    push_entry.last = (chan_q == LAST_ADDR);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_FETCH;
      ST_FETCH: if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (sweep_done) state_d = frame_start ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ram_chipselect = issue;
    busy           = (state_q != ST_IDLE);
    frame_done     = sweep_done;
    err_overrun    = frame_start && (state_q != ST_IDLE) && !sweep_done;
  end

  assign ram_address    = addr_q;
  assign ram_write      = 1'b0;
  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;
  assign coef_valid     = !fifo_empty;
  assign coef_data      = head.data;
  assign coef_chan      = head.chan;
  assign coef_last      = head.last;

  // Address counter, read tracking and FIFO pointers
  always_comb begin
    addr_d     = addr_q;
    chan_d     = chan_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    // The counter parks on the last address instead of wrapping.
    if (accept) begin
      addr_d = '0;
    end else if (issue && !last_issue) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    if (issue) begin
      chan_d = addr_q;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      chan_q     <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      chan_q     <= chan_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is cleared on reset so the stream outputs read zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!reset_n) !(push && fifo_full)
  );

`ifdef CALI_RD_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = '0;
    end else if (pop) begin
      sum_d = sum_q + head.data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  // Folds in the beat being accepted so the total is already complete in the frame_done cycle.
  assign coef_sum = pop ? (sum_q + head.data) : sum_q;
`endif

endmodule

// File: tb/tb_cali_ram_reader.sv
// Directed bench for cali_ram_reader: RAM model, stream scoreboard, overrun/reset/back-to-back cases.
module tb_cali_ram_reader;
  localparam int NUM_CH     = 320;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                frame_start;
  logic [ADDR_W-1:0]   ram_address;
  logic                ram_chipselect;
  logic                ram_write;
  logic [DATA_W/8-1:0] ram_byteenable;
  logic                ram_clken;
  logic [DATA_W-1:0]   ram_readdata;
  logic [DATA_W-1:0]   coef_data;
  logic [ADDR_W-1:0]   coef_chan;
  logic                coef_last;
  logic                coef_valid;
  logic                coef_ready;
  logic                busy;
  logic                frame_done;
  logic                err_overrun;
`ifdef CALI_RD_CHECKSUM_EN
  logic [DATA_W-1:0]   coef_sum;
`endif

  cali_ram_reader #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_byteenable(ram_byteenable), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
    .coef_data(coef_data), .coef_chan(coef_chan), .coef_last(coef_last),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .busy(busy),
    .frame_done(frame_done), .err_overrun(err_overrun)
`ifdef CALI_RD_CHECKSUM_EN
    , .coef_sum(coef_sum)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port-2 model: one-cycle registered read
  int pat = 0;
  logic [DATA_W-1:0] ram_q;

  function automatic logic [DATA_W-1:0] ram_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] x;
    x = DATA_W'(a);
    case (pat)
      0:       return x * 16'd3;
      1:       return 16'hA5A5 ^ (x * 16'd7);
      default: return 16'hFFFF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_chipselect) ram_q <= ram_val(ram_address);
  end
  assign ram_readdata = ram_q;

  // Checker
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and stream monitor (samples on the falling edge)
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] e_chan;
  int issued = 0, accepted = 0, occ = 0, max_occ = 0;
  int beat_cnt = 0, done_cnt = 0, ovr_cnt = 0, last_cnt = 0;
  int first_cyc = 0, last_cyc = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_chan;
  logic prev_last;

  always @(negedge clk) begin
    if (!reset_n) begin
      issued     = 0;
      accepted   = 0;
      prev_stall = 1'b0;
    end else begin
      occ = issued - accepted;
      if (occ > max_occ) max_occ = occ;
      if (occ >= FIFO_DEPTH) check_eq("cs_low_when_full", ram_chipselect, 1'b0);
      if (ram_chipselect) issued++;
      if (prev_stall) begin
        check_eq("hold_valid", coef_valid, 1'b1);
        check_eq("hold_data", coef_data, prev_data);
        check_eq("hold_chan", coef_chan, prev_chan);
        check_eq("hold_last", coef_last, prev_last);
      end
      if (coef_valid && coef_ready) begin
        accepted++;
        beat_cnt++;
        if (beat_cnt == 1) first_cyc = cyc;
        last_cyc = cyc;
        if (coef_last) last_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          e_chan = exp_q.pop_front();
          check_eq("beat_chan", coef_chan, e_chan);
          check_eq("beat_data", coef_data, ram_val(e_chan));
          check_eq("beat_last", coef_last, e_chan == ADDR_W'(NUM_CH - 1));
          check_eq("done_at_last", frame_done, e_chan == ADDR_W'(NUM_CH - 1));
        end
      end
      if (frame_done) done_cnt++;
      if (err_overrun) ovr_cnt++;
      prev_stall = coef_valid && !coef_ready;
      prev_data  = coef_data;
      prev_chan  = coef_chan;
      prev_last  = coef_last;
    end
  end

  // Driver tasks (called at posedge+1)
  task automatic push_sweep();
    for (int i = 0; i < NUM_CH; i++) exp_q.push_back(ADDR_W'(i));
  endtask

  task automatic start_pulse();
    push_sweep();
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (rnd) coef_ready = ($urandom_range(0, 9) < 3);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    coef_ready = 1'b1;
    check_eq("sweep_timeout", ok, 1'b1);
  endtask

  task automatic wait_frame_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("frame_done_timeout", ok, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b0, d0, o0;
  bit got100;

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    coef_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", coef_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cs", ram_chipselect, 1'b0);
    check_eq("rst_write", ram_write, 1'b0);
    check_eq("rst_be", ram_byteenable, 2'b11);
    check_eq("rst_clken", ram_clken, 1'b1);
    check_eq("rst_addr", ram_address, 0);
    check_eq("rst_data", coef_data, 0);
    check_eq("rst_chan", coef_chan, 0);
    check_eq("rst_last", coef_last, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_ovr", err_overrun, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Full sweep, ready held high: latency, throughput, single last/done
    pat = 0;
    push_sweep();
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    check_eq("t1_busy_rise", busy, 1'b1);
    check_eq("t1_cs_first", ram_chipselect, 1'b1);
    check_eq("t1_addr_first", ram_address, 0);
    check_eq("t1_valid_c1", coef_valid, 1'b0);
    @(posedge clk);
    #1 check_eq("t1_valid_c2", coef_valid, 1'b0);
    @(posedge clk);
    #1;
    check_eq("t1_valid_c3", coef_valid, 1'b1);
    check_eq("t1_chan0", coef_chan, 0);
    run_until_idle(1000, 1'b0);
    check_eq("t1_beats", beat_cnt, NUM_CH);
    check_eq("t1_back_to_back", last_cyc - first_cyc, NUM_CH - 1);
    check_eq("t1_last_cnt", last_cnt, 1);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_ovr_cnt", ovr_cnt, 0);
    check_eq("t1_sb_empty", exp_q.size(), 0);

    // Random backpressure at ~30% ready
    pat = 1;
    b0 = beat_cnt; d0 = done_cnt;
    start_pulse();
    run_until_idle(5000, 1'b1);
    check_eq("t2_beats", beat_cnt - b0, NUM_CH);
    check_eq("t2_done_cnt", done_cnt - d0, 1);
    check_eq("t2_sb_empty", exp_q.size(), 0);
    check_eq("t2_max_occ", max_occ, FIFO_DEPTH);

    // Triggers while busy at sweep cycles 1, 50 and 200
    pat = 0;
    b0 = beat_cnt; d0 = done_cnt; o0 = ovr_cnt;
    push_sweep();
    frame_start = 1'b1;
    for (int c = 1; c < 1000; c++) begin
      @(posedge clk);
      #1;
      frame_start = (c == 1) || (c == 50) || (c == 200);
      if (!busy) break;
    end
    frame_start = 1'b0;
    check_eq("t3_ovr_cnt", ovr_cnt - o0, 3);
    check_eq("t3_beats", beat_cnt - b0, NUM_CH);
    check_eq("t3_done_cnt", done_cnt - d0, 1);
    check_eq("t3_sb_empty", exp_q.size(), 0);

    // Trigger in the frame_done cycle: back-to-back sweeps
    pat = 1;
    b0 = beat_cnt; d0 = done_cnt; o0 = ovr_cnt;
    start_pulse();
    wait_frame_done(1000);
    push_sweep();
    frame_start = 1'b1;
    #1;
    check_eq("t4_ovr_in_done", err_overrun, 1'b0);
    @(posedge clk);
    #1 frame_start = 1'b0;
    check_eq("t4_busy_no_gap", busy, 1'b1);
    check_eq("t4_cs_restart", ram_chipselect, 1'b1);
    check_eq("t4_addr_restart", ram_address, 0);
    @(posedge clk);
    #1 check_eq("t4_valid_c2", coef_valid, 1'b0);
    @(posedge clk);
    #1;
    check_eq("t4_valid_c3", coef_valid, 1'b1);
    check_eq("t4_chan0", coef_chan, 0);
    run_until_idle(1000, 1'b0);
    check_eq("t4_beats", beat_cnt - b0, 2 * NUM_CH);
    check_eq("t4_done_cnt", done_cnt - d0, 2);
    check_eq("t4_ovr_cnt", ovr_cnt - o0, 0);
    check_eq("t4_sb_empty", exp_q.size(), 0);

    // Reset mid-sweep at beat 100
    pat = 0;
    b0 = beat_cnt; d0 = done_cnt;
    start_pulse();
    got100 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (beat_cnt - b0 >= 100) begin
        got100 = 1'b1;
        break;
      end
    end
    check_eq("t5_reach_100", got100, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_valid_async", coef_valid, 1'b0);
    check_eq("t5_busy_async", busy, 1'b0);
    check_eq("t5_cs_async", ram_chipselect, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("t5_no_done", done_cnt - d0, 0);
    check_eq("t5_idle_valid", coef_valid, 1'b0);
    check_eq("t5_idle_busy", busy, 1'b0);
    b0 = beat_cnt; d0 = done_cnt;
    start_pulse();
    run_until_idle(1000, 1'b0);
    check_eq("t5_beats", beat_cnt - b0, NUM_CH);
    check_eq("t5_done_cnt", done_cnt - d0, 1);
    check_eq("t5_sb_empty", exp_q.size(), 0);

`ifdef CALI_RD_CHECKSUM_EN
    // All-ones RAM: 320 * 0xFFFF mod 2^16 = 0xFEC0
    pat = 2;
    start_pulse();
    wait_frame_done(1000);
    check_eq("t6_sum_at_done", coef_sum, 16'hFEC0);
    run_until_idle(100, 1'b0);
    check_eq("t6_sum_held", coef_sum, 16'hFEC0);
    check_eq("t6_sb_empty", exp_q.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
